// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with parallel load, a wrap or saturate
// boundary mode, an enable prescaler, and terminal-count / sticky-overflow flags.
module counter_updown_mod #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_prescale;
  logic             r_tc;
  logic             r_ovf;

  logic             w_preLast;
  logic             w_step;
  logic             w_atMax;
  logic             w_atZero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_countNext;
  logic [PW-1:0]    w_prescaleNext;
  logic [WIDTH-1:0] w_loadClamped;

  assign w_preLast     = (r_prescale == PRE_TOP);
  assign w_step        = enable && w_preLast;
  assign w_atMax       = (r_count == MAX_CNT);
  assign w_atZero      = (r_count == '0);
  assign w_boundary    = w_step && (up_down ? w_atMax : w_atZero);
  assign w_loadClamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  // Boundary compare comes before the +/-1, so the count never leaves 0..MAX_VAL
  always_comb begin
    w_countNext = r_count;
    if (w_step) begin
      if (up_down) begin
        if (w_atMax) w_countNext = SATURATE ? MAX_CNT : '0;
        else         w_countNext = r_count + WIDTH'(1);
      end else begin
        if (w_atZero) w_countNext = SATURATE ? '0 : MAX_CNT;
        else          w_countNext = r_count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_prescaleNext = r_prescale;
    if (enable) begin
      if (w_preLast) w_prescaleNext = '0;
      else           w_prescaleNext = r_prescale + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_prescale <= '0;
      r_tc       <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (load) begin
      r_count    <= w_loadClamped;
      r_prescale <= '0;
      r_tc       <= 1'b0;
      if (clear_ovf) r_ovf <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_prescale <= w_prescaleNext;
      r_tc       <= w_boundary;
      // A boundary event in the same cycle as clear_ovf keeps the flag set
      r_ovf      <= w_boundary | (r_ovf & ~clear_ovf);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign zero  = (r_count == '0);

endmodule
